// File: rtl/rv32v_wb_sequencer.sv
// rv32v_wb_sequencer: turns NUM_LANES-wide vector result beats into register-file writes and retires the instruction.
module rv32v_wb_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int VL_WIDTH  = 7
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [4:0]                start_vd,
  input  logic [VL_WIDTH:0]         start_vl,
  input  logic [1:0]                start_sew,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [32*NUM_LANES-1:0]   res_data,
  output logic                      rf_wen,
  output logic [NUM_LANES-1:0]      rf_lane_en,
  output logic [4:0]                rf_vd,
  output logic [VL_WIDTH-1:0]       rf_vd_offset,
  output logic [32*NUM_LANES-1:0]   rf_w_data,
  output logic [1:0]                rf_sew,
  output logic [VL_WIDTH:0]         rf_vl,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [VL_WIDTH:0]   offset;
  logic [VL_WIDTH+1:0] off_next;
  logic                start_acc, beat_acc, last_beat;
  logic [NUM_LANES-1:0] lane_en_n;
  always_comb begin
    start_ready = state == IDLE;
    res_ready   = state == WRITE && !flush;
    busy        = state != IDLE;
    done        = state == DONE && !flush;
    start_acc   = start_valid && start_ready && !flush;
    beat_acc    = res_valid && res_ready;
    // one extra bit so offset+NUM_LANES past vl=2**VL_WIDTH cannot wrap
    off_next    = {1'b0, offset} + (VL_WIDTH+2)'(NUM_LANES);
    last_beat   = off_next >= {1'b0, rf_vl};
    lane_en_n   = '0;
    for (int i = 0; i < NUM_LANES; i++)
      lane_en_n[i] = ({1'b0, offset} + (VL_WIDTH+2)'(i)) < {1'b0, rf_vl};
    state_n = flush ? IDLE :
              state == IDLE  ? (start_acc ? (start_vl == '0 ? DONE : WRITE) : IDLE) :
              state == WRITE ? (beat_acc && last_beat ? DONE : WRITE) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      offset       <= '0;
      rf_wen       <= 1'b0;
      rf_lane_en   <= '0;
      rf_vd        <= '0;
      rf_vd_offset <= '0;
      rf_w_data    <= '0;
      rf_sew       <= '0;
      rf_vl        <= '0;
    end else begin
      state  <= state_n;
      rf_wen <= beat_acc;
      if (flush) begin
        offset <= '0;
      end else if (start_acc) begin
        offset <= '0;
        rf_vd  <= start_vd;
        rf_vl  <= start_vl;
        rf_sew <= start_sew;
      end else if (beat_acc) begin
        offset       <= off_next[VL_WIDTH:0];
        rf_w_data    <= res_data;
        rf_vd_offset <= offset[VL_WIDTH-1:0];
        rf_lane_en   <= lane_en_n;
      end
    end
  end
endmodule
